// File: rtl/mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_ctrl
//  Description : Word memory with en/rw request, programmable wait states and
//                an MFC (memory-function-complete) handshake. Addresses below
//                INIT_WORDS read INIT_VAL until first written; addresses at or
//                above DEPTH are reported through err.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   in   1       system clock, rising edge
//    rst   in   1       asynchronous active-high reset
//    en    in   1       request strobe, held high until MFC is seen
//    rw    in   1       1 = read, 0 = write
//    addr  in   ADDR_W  word address
//    din   in   DATA_W  write data
//    dout  out  DATA_W  registered read data
//    MFC   out  1       registered access-complete flag
//    busy  out  1       request in progress (WAIT or ACCESS)
//    err   out  1       registered: last completed access was out of range
// ============================================================================
module mem_wait_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 4,
    parameter int INIT_WORDS  = 8,
    parameter int INIT_VAL    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              MFC,
    output logic              busy,
    output logic              err
);

    localparam int                c_IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Range limits carry one extra bit so DEPTH == 2**ADDR_W still fits.
    localparam logic [ADDR_W:0]   c_DEPTH      = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_INIT_WORDS = (ADDR_W + 1)'(INIT_WORDS);
    localparam logic [DATA_W-1:0] c_INIT_VAL   = DATA_W'(INIT_VAL);
    localparam logic [3:0]        c_WAIT       = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT_S = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    // Request registers: the access uses only what was captured in IDLE.
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [DATA_W-1:0] r_din;
    logic [3:0]        r_cnt;

    logic [DATA_W-1:0] r_dout;
    logic              r_mfc;
    logic              r_err;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;

    logic              w_in_range;
    logic              w_in_init;
    logic [c_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0] w_rdata;
    logic              w_wr;

    assign w_in_range = ({1'b0, r_addr} < c_DEPTH);
    assign w_in_init  = ({1'b0, r_addr} < c_INIT_WORDS);
    // Only meaningful once w_in_range holds, so the upper bits never alias.
    assign w_idx      = r_addr[c_IDX_W-1:0];
    assign w_rdata    = r_valid[w_idx] ? r_mem[w_idx]
                      : (w_in_init ? c_INIT_VAL : '0);
    assign w_wr       = (r_state == c_ACCESS) && !r_rw && w_in_range;

    assign dout = r_dout;
    assign MFC  = r_mfc;
    assign err  = r_err;
    assign busy = (r_state == c_WAIT_S) || (r_state == c_ACCESS);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (en) begin
                    w_next_state = (WAIT_CYCLES == 0) ? c_ACCESS : c_WAIT_S;
                end
            end
            c_WAIT_S: begin
                // Dropping en while waiting abandons the request.
                if (!en) begin
                    w_next_state = c_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_next_state = c_ACCESS;
                end
            end
            c_ACCESS: begin
                w_next_state = c_DONE;
            end
            c_DONE: begin
                // en must be seen low before another request is taken.
                if (!en) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture, wait counter, outputs and valid bits
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_rw    <= 1'b1;
            r_din   <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_mfc   <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (en) begin
                        r_addr <= addr;
                        r_rw   <= rw;
                        r_din  <= din;
                        r_cnt  <= c_WAIT;
                    end
                end
                c_WAIT_S: begin
                    if (en) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ACCESS: begin
                    r_mfc <= 1'b1;
                    r_err <= !w_in_range;
                    if (r_rw) begin
                        r_dout <= w_in_range ? w_rdata : '0;
                    end else if (w_in_range) begin
                        r_valid[w_idx] <= 1'b1;
                    end
                end
                c_DONE: begin
                    if (!en) begin
                        r_mfc <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Storage array; contents after reset are irrelevant because the valid
    // bits decide what a read returns.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= r_din;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wait_ctrl
//  Description : Directed self-checking bench for mem_wait_ctrl. dut0 uses
//                four wait states, dut1 uses none.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wait_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en0;
    logic        en1;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] din;

    logic [15:0] dout0;
    logic        mfc0;
    logic        busy0;
    logic        err0;
    logic [15:0] dout1;
    logic        mfc1;
    logic        busy1;
    logic        err1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wait_ctrl #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(256),
        .WAIT_CYCLES(4), .INIT_WORDS(8), .INIT_VAL(1)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en0), .rw(rw), .addr(addr), .din(din),
        .dout(dout0), .MFC(mfc0), .busy(busy0), .err(err0)
    );

    mem_wait_ctrl #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(256),
        .WAIT_CYCLES(0), .INIT_WORDS(8), .INIT_VAL(1)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en1), .rw(rw), .addr(addr), .din(din),
        .dout(dout1), .MFC(mfc1), .busy(busy1), .err(err1)
    );

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic start0(input logic r, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        rw = r; addr = a; din = d; en0 = 1'b1;
        @(posedge clk); #1;
    endtask

    // Edges after the capture edge until MFC; 0 means it never came.
    task automatic wait_mfc0(output int lat);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (mfc0) lat = i;
        end
    endtask

    task automatic access0(input logic r, input logic [15:0] a, input logic [15:0] d,
                           output int lat);
        start0(r, a, d);
        wait_mfc0(lat);
    endtask

    task automatic drop0;
        @(negedge clk);
        en0 = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0; rw = 1'b1; addr = '0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dout0, mfc0, busy0, err0} !== 19'h0) begin
            failures++;
            $display("FAIL reset_dut0: got dout=%h mfc=%b busy=%b err=%b expected all 0",
                     dout0, mfc0, busy0, err0);
        end
        checks++;
        if ({dout1, mfc1, busy1, err1} !== 19'h0) begin
            failures++;
            $display("FAIL reset_dut1: got dout=%h mfc=%b busy=%b err=%b expected all 0",
                     dout1, mfc1, busy1, err1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_latency;
        logic exp_busy;
        logic exp_mfc;
        start0(1'b1, 16'd3, 16'h0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            exp_busy = (k <= 4);
            exp_mfc  = (k == 5);
            checks++;
            if (busy0 !== exp_busy || mfc0 !== exp_mfc) begin
                failures++;
                $display("FAIL latency_T+%0d: got busy=%b mfc=%b expected busy=%b mfc=%b",
                         k, busy0, mfc0, exp_busy, exp_mfc);
            end
        end
        checks++;
        if (dout0 !== 16'h0001 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL init_read: got dout=%h err=%b expected 0001 0", dout0, err0);
        end
        drop0();
        checks++;
        if (mfc0 !== 1'b0) begin
            failures++;
            $display("FAIL mfc_release: got %b expected 0", mfc0);
        end
    endtask

    task automatic test_read_write;
        int lat;
        access0(1'b1, 16'd100, 16'h0, lat);
        checks++;
        if (lat !== 5 || dout0 !== 16'h0000) begin
            failures++;
            $display("FAIL read_unwritten: got lat=%0d dout=%h expected 5 0000", lat, dout0);
        end
        drop0();
        access0(1'b0, 16'd3, 16'hBEEF, lat);
        checks++;
        if (lat !== 5 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL write3: got lat=%0d err=%b expected 5 0", lat, err0);
        end
        drop0();
        access0(1'b1, 16'd3, 16'h0, lat);
        checks++;
        if (dout0 !== 16'hBEEF) begin
            failures++;
            $display("FAIL readback3: got %h expected beef", dout0);
        end
        drop0();
        access0(1'b0, 16'd4, 16'h7777, lat);
        checks++;
        if (dout0 !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_keeps_dout: got %h expected beef", dout0);
        end
        drop0();
    endtask

    task automatic test_out_of_range;
        int lat;
        access0(1'b0, 16'd300, 16'h1234, lat);
        checks++;
        if (lat !== 5 || err0 !== 1'b1) begin
            failures++;
            $display("FAIL oor_write: got lat=%0d err=%b expected 5 1", lat, err0);
        end
        drop0();
        access0(1'b1, 16'd44, 16'h0, lat);
        checks++;
        if (dout0 !== 16'h0000 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL no_alias44: got dout=%h err=%b expected 0000 0", dout0, err0);
        end
        drop0();
        access0(1'b1, 16'd3, 16'h0, lat);
        drop0();
        access0(1'b1, 16'd256, 16'h0, lat);
        checks++;
        if (dout0 !== 16'h0000 || err0 !== 1'b1) begin
            failures++;
            $display("FAIL oor_read256: got dout=%h err=%b expected 0000 1", dout0, err0);
        end
        drop0();
        access0(1'b1, 16'd255, 16'h0, lat);
        checks++;
        if (dout0 !== 16'h0000 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL read255: got dout=%h err=%b expected 0000 0", dout0, err0);
        end
        drop0();
        access0(1'b1, 16'd7, 16'h0, lat);
        checks++;
        if (dout0 !== 16'h0001) begin
            failures++;
            $display("FAIL init_edge7: got %h expected 0001", dout0);
        end
        drop0();
        access0(1'b1, 16'd8, 16'h0, lat);
        checks++;
        if (dout0 !== 16'h0000) begin
            failures++;
            $display("FAIL past_init8: got %h expected 0000", dout0);
        end
        drop0();
    endtask

    task automatic test_abort;
        int lat;
        access0(1'b1, 16'd3, 16'h0, lat);
        drop0();
        start0(1'b0, 16'd10, 16'hAAAA);
        @(posedge clk); #1;
        @(negedge clk);
        en0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy0 !== 1'b0 || mfc0 !== 1'b0 || dout0 !== 16'hBEEF) begin
            failures++;
            $display("FAIL abort: got busy=%b mfc=%b dout=%h expected 0 0 beef",
                     busy0, mfc0, dout0);
        end
        access0(1'b1, 16'd10, 16'h0, lat);
        checks++;
        if (lat !== 5 || dout0 !== 16'h0000) begin
            failures++;
            $display("FAIL abort_nowrite: got lat=%0d dout=%h expected 5 0000", lat, dout0);
        end
        drop0();
    endtask

    task automatic test_done_hold;
        int lat;
        access0(1'b1, 16'd3, 16'h0, lat);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (mfc0 !== 1'b1 || busy0 !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: got mfc=%b busy=%b expected 1 0", k, mfc0, busy0);
            end
        end
        drop0();
        access0(1'b1, 16'd4, 16'h0, lat);
        checks++;
        if (lat !== 5 || dout0 !== 16'h7777) begin
            failures++;
            $display("FAIL fresh_access: got lat=%0d dout=%h expected 5 7777", lat, dout0);
        end
        drop0();
    endtask

    task automatic test_reset_abort;
        int lat;
        access0(1'b1, 16'd3, 16'h0, lat);
        drop0();
        start0(1'b0, 16'd20, 16'h5555);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout0, mfc0, busy0, err0} !== 19'h0) begin
            failures++;
            $display("FAIL rst_in_wait: got dout=%h mfc=%b busy=%b err=%b expected all 0",
                     dout0, mfc0, busy0, err0);
        end
        en0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access0(1'b1, 16'd20, 16'h0, lat);
        checks++;
        if (dout0 !== 16'h0000) begin
            failures++;
            $display("FAIL rst_nowrite: got %h expected 0000", dout0);
        end
        drop0();
        access0(1'b0, 16'd2, 16'h2222, lat);
        drop0();
        access0(1'b1, 16'd2, 16'h0, lat);
        checks++;
        if (dout0 !== 16'h2222) begin
            failures++;
            $display("FAIL readback2: got %h expected 2222", dout0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dout0 !== 16'h0000 || mfc0 !== 1'b0 || err0 !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_done: got dout=%h mfc=%b err=%b expected 0 0 0",
                     dout0, mfc0, err0);
        end
        en0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access0(1'b1, 16'd2, 16'h0, lat);
        checks++;
        if (dout0 !== 16'h0001) begin
            failures++;
            $display("FAIL valid_cleared: got %h expected 0001", dout0);
        end
        drop0();
    endtask

    task automatic test_zero_wait;
        @(negedge clk);
        rw = 1'b1; addr = 16'd3; din = '0; en1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mfc1 !== 1'b0 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL zw_T: got mfc=%b busy=%b expected 0 1", mfc1, busy1);
        end
        @(posedge clk); #1;
        checks++;
        if (mfc1 !== 1'b1 || dout1 !== 16'h0001 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL zw_T+1: got mfc=%b dout=%h busy=%b expected 1 0001 0",
                     mfc1, dout1, busy1);
        end
        @(negedge clk);
        en1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mfc1 !== 1'b0) begin
            failures++;
            $display("FAIL zw_release: got %b expected 0", mfc1);
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_read_write();
        test_out_of_range();
        test_abort();
        test_done_hold();
        test_reset_abort();
        test_zero_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
